// File: rtl/adc_calib_pkg.sv
// adc_calib_pkg: shared widths, reset constants and saturation limits for the ADC calibration path.
package adc_calib_pkg;
    localparam int CODE_W_DEF    = 24;
    localparam int GAIN_W_DEF    = 32;
    localparam int GAIN_FRAC_DEF = 40;
    localparam int OUT_W_DEF     = 32;
    localparam int OUT_FRAC_DEF  = 20;
    localparam int SHIFT_DEF     = GAIN_FRAC_DEF - OUT_FRAC_DEF;
    localparam int PROD_W_DEF    = CODE_W_DEF + 1 + GAIN_W_DEF;

    localparam longint GAIN_RST_DEF   = 1310720;
    localparam longint OFFSET_RST_DEF = -10485760;

    localparam longint SAT_MAX_DEF = (longint'(1) <<< (OUT_W_DEF - 1)) - 1;
    localparam longint SAT_MIN_DEF = -SAT_MAX_DEF - 1;
endpackage

// File: rtl/adc_calib_apply_round_sat.sv
// calib_round_sat: round-half-up shift of the full product, offset add and clamp to the output range.
module calib_round_sat
    import adc_calib_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic signed [PROD_W-1:0] prod,
    input  logic signed [OUT_W-1:0]  offset,
    output logic        [OUT_W-1:0]  value,
    output logic                     sat
);
    localparam int SUM_W = OUT_W + 6;
    localparam int SHR_W = PROD_W - SHIFT;
    localparam logic signed [SUM_W-1:0] HI = SUM_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] LO = ~HI;

    logic signed [PROD_W-1:0] rnd;
    logic signed [SHR_W-1:0]  shr;
    logic signed [SUM_W-1:0]  sum;
    logic                     hi;
    logic                     lo;

    assign rnd   = prod + (PROD_W'(1) << (SHIFT - 1));
    assign shr   = SHR_W'(rnd >>> SHIFT);
    assign sum   = SUM_W'(shr) + SUM_W'(offset);
    assign hi    = sum > HI;
    assign lo    = sum < LO;
    assign sat   = hi | lo;
    assign value = hi ? HI[OUT_W-1:0] : lo ? LO[OUT_W-1:0] : sum[OUT_W-1:0];
endmodule

// File: rtl/adc_calib_apply.sv
// adc_calib_apply: applies streamed gain/offset to raw ADC codes through a 3-stage
// elastic pipeline, producing a saturated signed fixed-point volts stream.
module adc_calib_apply
    import adc_calib_pkg::*;
#(
    parameter int     CODE_W     = CODE_W_DEF,
    parameter int     GAIN_W     = GAIN_W_DEF,
    parameter int     GAIN_FRAC  = GAIN_FRAC_DEF,
    parameter int     OUT_W      = OUT_W_DEF,
    parameter int     OUT_FRAC   = OUT_FRAC_DEF,
    parameter longint GAIN_RST   = GAIN_RST_DEF,
    parameter longint OFFSET_RST = OFFSET_RST_DEF
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic [GAIN_W-1:0] gain_s_axis_tdata,
    input  logic              gain_s_axis_tvalid,
    output logic              gain_s_axis_tready,
    input  logic [OUT_W-1:0]  offset_s_axis_tdata,
    input  logic              offset_s_axis_tvalid,
    output logic              offset_s_axis_tready,
    input  logic [CODE_W-1:0] adc_s_axis_tdata,
    input  logic              adc_s_axis_tvalid,
    output logic              adc_s_axis_tready,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              i_sat_clr,
    output logic              o_sat_sticky,
    output logic [31:0]       o_sample_cnt
);
    localparam int SHIFT  = GAIN_FRAC - OUT_FRAC;
    localparam int PROD_W = CODE_W + 1 + GAIN_W;

    logic                     v1, v2, v3;
    logic                     en1, en2, en3;
    logic signed [GAIN_W-1:0] gain_act, gain1;
    logic signed [OUT_W-1:0]  off_act, off1, off2;
    logic signed [CODE_W:0]   code1;
    logic signed [PROD_W-1:0] prod2;
    logic        [OUT_W-1:0]  res;
    logic                     res_sat, sat3;
    logic        [31:0]       sample_cnt;
    logic                     out_hs;

    // A stage may load when empty or when its contents move on this edge.
    assign en3 = ~v3 | m_axis_tready;
    assign en2 = ~v2 | en3;
    assign en1 = ~v1 | en2;

    assign adc_s_axis_tready    = en1;
    assign gain_s_axis_tready   = s00_axi_aresetn;
    assign offset_s_axis_tready = s00_axi_aresetn;
    assign m_axis_tvalid        = v3;
    assign out_hs               = v3 & m_axis_tready;
    assign o_sample_cnt         = sample_cnt;

    calib_round_sat #(.PROD_W(PROD_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_sat (
        .prod   (prod2),
        .offset (off2),
        .value  (res),
        .sat    (res_sat)
    );

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            gain_act <= GAIN_W'(GAIN_RST);
            off_act  <= OUT_W'(OFFSET_RST);
        end else begin
            if (gain_s_axis_tvalid & gain_s_axis_tready) gain_act <= gain_s_axis_tdata;
            if (offset_s_axis_tvalid & offset_s_axis_tready) off_act <= offset_s_axis_tdata;
        end
    end

    // S1 snapshots the parameters so each sample sees one coherent pair.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            v1    <= 1'b0;
            code1 <= '0;
            gain1 <= '0;
            off1  <= '0;
        end else if (en1) begin
            v1 <= adc_s_axis_tvalid;
            if (adc_s_axis_tvalid) begin
                code1 <= {1'b0, adc_s_axis_tdata};
                gain1 <= gain_act;
                off1  <= off_act;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            v2    <= 1'b0;
            prod2 <= '0;
            off2  <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                prod2 <= PROD_W'(code1) * PROD_W'(gain1);
                off2  <= off1;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            v3           <= 1'b0;
            m_axis_tdata <= '0;
            sat3         <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                m_axis_tdata <= res;
                sat3         <= res_sat;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            o_sat_sticky <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            o_sat_sticky <= (out_hs & sat3) | (o_sat_sticky & ~i_sat_clr);
            sample_cnt   <= sample_cnt + 32'(out_hs);
        end
    end
endmodule

// File: tb/tb_adc_calib_apply.sv
// tb_adc_calib_apply: directed and random stimulus checked against an arithmetic
// reference of the calibration formula plus a queue of in-flight samples.
module tb_adc_calib_apply;
    import adc_calib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gain_tdata;
    logic        gain_tvalid, gain_tready;
    logic [31:0] offset_tdata;
    logic        offset_tvalid, offset_tready;
    logic [23:0] adc_tdata;
    logic        adc_tvalid, adc_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready;
    logic        sat_clr, sat_sticky;
    logic [31:0] sample_cnt;

    always #5 clk = ~clk;

    adc_calib_apply dut (
        .s00_axi_aclk         (clk),
        .s00_axi_aresetn      (rst_n),
        .gain_s_axis_tdata    (gain_tdata),
        .gain_s_axis_tvalid   (gain_tvalid),
        .gain_s_axis_tready   (gain_tready),
        .offset_s_axis_tdata  (offset_tdata),
        .offset_s_axis_tvalid (offset_tvalid),
        .offset_s_axis_tready (offset_tready),
        .adc_s_axis_tdata     (adc_tdata),
        .adc_s_axis_tvalid    (adc_tvalid),
        .adc_s_axis_tready    (adc_tready),
        .m_axis_tdata         (m_tdata),
        .m_axis_tvalid        (m_tvalid),
        .m_axis_tready        (m_tready),
        .i_sat_clr            (sat_clr),
        .o_sat_sticky         (sat_sticky),
        .o_sample_cnt         (sample_cnt)
    );

    typedef struct {
        longint data;
        bit     sat;
        int     acc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    longint      gain_m, off_m;
    bit          sticky_m;
    logic [31:0] cnt_m;
    bit          held = 0;
    logic [31:0] held_data;
    logic [31:0] c0;
    int          a0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // out = clamp(floor((code*gain + half) / 2^SHIFT) + offset)
    function automatic longint ref_out(longint code, longint g, longint o, output bit s);
        longint v;
        v = ((code * g + (longint'(1) <<< (SHIFT_DEF - 1))) >>> SHIFT_DEF) + o;
        s = v > SAT_MAX_DEF || v < SAT_MIN_DEF;
        return v > SAT_MAX_DEF ? SAT_MAX_DEF : v < SAT_MIN_DEF ? SAT_MIN_DEF : v;
    endfunction

    // Called at a falling edge with inputs already driven; checks, updates the model, advances one clock.
    task automatic cycle();
        exp_t e;
        bit   hs, sat;
        #1;
        if (held) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", 64'(m_tdata), 64'(held_data));
        end
        chk("m_valid", 64'(m_tvalid), 64'(q.size() > 0 && cyc - q[0].acc >= 3));
        chk("adc_ready", 64'(adc_tready), 64'(q.size() < 3 || m_tready));
        chk("sticky", 64'(sat_sticky), 64'(sticky_m));
        chk("cnt", 64'(sample_cnt), 64'(cnt_m));
        chk("par_ready", 64'({gain_tready, offset_tready}), 64'd3);
        hs  = m_tvalid && m_tready;
        sat = 0;
        if (hs && q.size() > 0) begin
            e   = q.pop_front();
            sat = e.sat;
            chk("data", 64'(m_tdata), 64'(e.data[31:0]));
        end
        sticky_m  = sat || (sticky_m && !sat_clr);
        cnt_m     = cnt_m + 32'(hs);
        held      = m_tvalid && !m_tready;
        held_data = m_tdata;
        if (adc_tvalid && adc_tready) begin
            e.data = ref_out(longint'(adc_tdata), gain_m, off_m, e.sat);
            e.acc  = cyc;
            q.push_back(e);
            acc_cnt++;
        end
        if (gain_tvalid) gain_m = longint'($signed(gain_tdata));
        if (offset_tvalid) off_m = longint'($signed(offset_tdata));
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(int n);
        adc_tvalid    = 0;
        gain_tvalid   = 0;
        offset_tvalid = 0;
        m_tready      = 1;
        repeat (n) cycle();
    endtask

    initial begin
        logic [23:0] t1 [3];
        t1 = '{24'h000000, 24'h800000, 24'hFFFFFF};
        rst_n = 0;
        gain_tdata = 0; gain_tvalid = 0; offset_tdata = 0; offset_tvalid = 0;
        adc_tdata = 0; adc_tvalid = 0; m_tready = 0; sat_clr = 0;
        gain_m = GAIN_RST_DEF; off_m = OFFSET_RST_DEF; sticky_m = 0; cnt_m = 0;
        #1;
        chk("rst_valid", 64'(m_tvalid), 64'd0);
        chk("rst_data", 64'(m_tdata), 64'd0);
        chk("rst_sticky", 64'(sat_sticky), 64'd0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_par_ready", 64'({gain_tready, offset_tready}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // reset parameters across the code range
        m_tready   = 1;
        adc_tvalid = 1;
        foreach (t1[i]) begin
            adc_tdata = t1[i];
            cycle();
        end
        drain(6);

        // saturation, then clear colliding with a saturating handshake
        gain_tvalid = 1; gain_tdata = 32'h7FFFFFFF;
        offset_tvalid = 1; offset_tdata = 32'h7FFFFFFF;
        cycle();
        gain_tvalid = 0; offset_tvalid = 0;
        adc_tvalid = 1; adc_tdata = 24'hFFFFFF;
        cycle();
        drain(4);
        chk("t2_sticky", 64'(sat_sticky), 64'd1);
        adc_tvalid = 1;
        cycle();
        adc_tvalid = 0;
        cycle();
        cycle();
        sat_clr = 1;
        cycle();
        sat_clr = 0;
        chk("t2_set_wins", 64'(sat_sticky), 64'd1);
        sat_clr = 1;
        cycle();
        sat_clr = 0;
        chk("t2_cleared", 64'(sat_sticky), 64'd0);
        gain_tvalid = 1; gain_tdata = 32'(GAIN_RST_DEF);
        offset_tvalid = 1; offset_tdata = 32'(OFFSET_RST_DEF);
        cycle();
        drain(2);

        // offset update on the same edge as a sample
        offset_tvalid = 1; offset_tdata = 32'h00123456;
        adc_tvalid = 1; adc_tdata = 24'h800000;
        cycle();
        offset_tvalid = 0;
        cycle();
        drain(5);

        // burst of 8 with a 5-cycle downstream stall
        c0 = sample_cnt;
        a0 = acc_cnt;
        for (int i = 0; i < 30; i++) begin
            adc_tvalid = (acc_cnt - a0) < 8;
            adc_tdata  = 24'($urandom);
            m_tready   = !(i >= 4 && i < 9);
            cycle();
        end
        drain(6);
        chk("t4_accepted", 64'(acc_cnt - a0), 64'd8);
        chk("t4_cnt", 64'(sample_cnt - c0), 64'd8);

        // reset with samples in flight
        gain_tvalid = 1; gain_tdata = 32'(2 * GAIN_RST_DEF);
        cycle();
        gain_tvalid = 0;
        adc_tvalid = 1;
        repeat (3) begin
            adc_tdata = 24'($urandom);
            cycle();
        end
        adc_tvalid = 0;
        #2 rst_n = 0;
        #1;
        chk("t5_valid", 64'(m_tvalid), 64'd0);
        chk("t5_par_ready", 64'({gain_tready, offset_tready}), 64'd0);
        q.delete();
        gain_m = GAIN_RST_DEF; off_m = OFFSET_RST_DEF; sticky_m = 0; cnt_m = 0; held = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        adc_tvalid = 1; adc_tdata = 0;
        cycle();
        drain(5);

        // counter wrap
        force dut.sample_cnt = 32'hFFFFFFFE;
        #1;
        release dut.sample_cnt;
        cnt_m = 32'hFFFFFFFE;
        adc_tvalid = 1;
        repeat (2) begin
            adc_tdata = 24'($urandom);
            cycle();
        end
        drain(5);
        chk("t6_wrap", 64'(sample_cnt), 64'd0);

        // random traffic with parameter updates and clears
        repeat (300) begin
            adc_tvalid    = $urandom_range(0, 3) != 0;
            adc_tdata     = 24'($urandom);
            m_tready      = $urandom_range(0, 3) != 0;
            gain_tvalid   = $urandom_range(0, 15) == 0;
            gain_tdata    = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 2621440);
            offset_tvalid = $urandom_range(0, 15) == 0;
            offset_tdata  = $urandom_range(0, 3) == 0 ? $urandom
                            : 32'(OFFSET_RST_DEF + longint'($urandom_range(0, 20971520)));
            sat_clr       = $urandom_range(0, 7) == 0;
            cycle();
        end
        sat_clr = 0;
        drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_calib_apply.md
Name: adc_calib_apply

Overview:
- AXI-Stream consumer of the calibration parameters that the calc-value block drives (gain/offset per channel).
- Applies them to a raw unsigned ADC code stream as out = sat(round(code*gain >> SHIFT) + offset).
- Emits a signed fixed-point volts stream with full tready backpressure.
- One instance per ADC channel, between the ADC interface and the control/DSP chain.

Parameters:
CODE_W, 24, raw ADC code width (unsigned).
GAIN_W, 32, signed gain width.
GAIN_FRAC, 40, gain fractional bits.
OUT_W, 32, signed output and offset width.
OUT_FRAC, 20, output/offset fractional bits (requires GAIN_FRAC > OUT_FRAC).
GAIN_RST, 1310720, gain value loaded at reset (1.192 uV/LSB).
OFFSET_RST, -10485760, offset value loaded at reset (-10 V).

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
gain_s_axis_tdata  in  GAIN_W  new gain value
gain_s_axis_tvalid  in  1  gain valid
gain_s_axis_tready  out  1  gain ready
offset_s_axis_tdata  in  OUT_W  new offset value
offset_s_axis_tvalid  in  1  offset valid
offset_s_axis_tready  out  1  offset ready
adc_s_axis_tdata  in  CODE_W  raw ADC code
adc_s_axis_tvalid  in  1  code valid
adc_s_axis_tready  out  1  code ready
m_axis_tdata  out  OUT_W  calibrated value, Q(OUT_W-OUT_FRAC).OUT_FRAC
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
i_sat_clr  in  1  clear sticky saturation flag
o_sat_sticky  out  1  saturation occurred since last clear
o_sample_cnt  out  32  count of output handshakes

Behaviour:
Reset values:
- All stage valids = 0.
- m_axis_tvalid = 0, m_axis_tdata = 0.
- Active gain = GAIN_RST, active offset = OFFSET_RST.
- o_sat_sticky = 0, o_sample_cnt = 0.
- gain/offset tready = 0 while reset is asserted, constant 1 otherwise.

Parameter capture:
- On a gain or offset handshake, the active register updates on that edge.
- Gain and offset update independently of each other.

Pipeline: three stages, each with its own valid bit; latency 3 cycles from adc handshake to m_axis_tvalid with no stall.
- S1: register code, zero-extended to CODE_W+1 signed. Snapshot active gain and offset into S1.
  - A sample accepted on the same edge as a parameter handshake uses the OLD value.
  - Every sample uses one consistent gain/offset pair from its S1 snapshot.
- S2: signed product, CODE_W+1+GAIN_W bits, full precision.
- S3: add 2^(GAIN_FRAC-OUT_FRAC-1), arithmetic-shift right by GAIN_FRAC-OUT_FRAC (round half up), sign-extend, add offset in OUT_W+6 bits.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; flag sat when clamped.
  - S3 registers are the m_axis outputs.

Handshake:
- Stage i advances when ~valid_i | ready_{i+1}; ready after S3 is m_axis_tready.
- adc_s_axis_tready = ~valid_S1 | ready_S2 (combinational, bubbles collapse).
- m_axis_tdata is held stable while tvalid & ~tready. No sample is dropped or duplicated.

Status:
- o_sat_sticky sets on an output handshake whose sample saturated.
- i_sat_clr clears it; if set and clear occur on the same cycle, set wins.
- o_sample_cnt increments per m_axis handshake and wraps 0xFFFFFFFF -> 0.

Reset mid-operation: all in-flight samples are discarded and parameters return to their reset values.

Decomposition:
- Package adc_calib_pkg: CODE_W/GAIN_W/OUT_W defaults, derived SHIFT = GAIN_FRAC-OUT_FRAC, reset constants, saturation limit constants.
- One sub-module, calib_round_sat: combinational round/shift/add/saturate for S3; returns value and sat bit.

Test Plan:
1. Reset defaults, codes 0, 0x800000, 0xFFFFFF with tready=1 -> outputs -10485760, 0, 10485759 on cycles 3, 4, 5 after the first handshake.
2. Gain=0x7FFFFFFF, offset=0x7FFFFFFF, code 0xFFFFFF -> out 0x7FFFFFFF and o_sat_sticky=1; assert i_sat_clr and a saturating handshake on the same cycle -> flag stays 1.
3. Offset handshake on the same edge as code 0x800000 -> that sample outputs 0 (old offset); the next code 0x800000 outputs the new offset.
4. Stream 8 back-to-back codes, hold m_axis_tready=0 for 5 cycles mid-burst -> adc tready drops after 3 buffered samples, data held stable, all 8 outputs in order, o_sample_cnt=8.
5. Assert reset with 3 samples in flight -> m_axis_tvalid=0 immediately, parameters restored; code 0 after release -> -10485760.
6. Preload o_sample_cnt near wrap via force, perform 2 handshakes -> 0xFFFFFFFF then 0.
